// File: rtl/yutorina_spm_dpx_pkg.sv
// Shared types and constants for the dual-port scratchpad.
// Bus encodings for read/write select and active-low strobes.
package yutorina_spm_dpx_pkg;

    typedef enum logic {
        YUTORINA_SPM_STATE_CLEAR = 1'b0,
        YUTORINA_SPM_STATE_RUN   = 1'b1
    } spm_state_t;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BYTE_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 12;

endpackage

// File: rtl/yutorina_spm_ram_core.sv
// Inferred true-dual-port RAM with byte-lane writes, read-first, no reset.
// Same-word same-edge writes must be lane-disjoint; port B is applied last.
module yutorina_spm_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                             clock,
    input  logic                             a_re,
    input  logic                             a_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]            a_addr,
    input  logic [DATA_WIDTH-1:0]            a_wdata,
    output logic [DATA_WIDTH-1:0]            a_rdata,
    input  logic                             b_re,
    input  logic                             b_we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]            b_addr,
    input  logic [DATA_WIDTH-1:0]            b_wdata,
    output logic [DATA_WIDTH-1:0]            b_rdata
);
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (a_re) a_rdata <= mem[a_addr];
        if (b_re) b_rdata <= mem[b_addr];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (a_we && a_be[i])
                mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (b_we && b_be[i])
                mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

endmodule

// File: rtl/yutorina_spm_dpx.sv
// Dual-port scratchpad: zero-fill FSM, lane arbitration, ack/collision regs.
// Define YUTORINA_SPM_BYPASS_EN to forward same-cycle writes to the other port's read.
module yutorina_spm_dpx
    import yutorina_spm_dpx_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int BYTE_WIDTH     = DEFAULT_BYTE_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clock,
    input  logic                             reset_,
    input  logic [ADDR_WIDTH-1:0]            instruction_address,
    input  logic                             instruction_address_strobe_,
    input  logic                             instruction_read_write,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] instruction_byte_enable,
    input  logic [DATA_WIDTH-1:0]            instruction_write_data,
    output logic [DATA_WIDTH-1:0]            instruction_read_data,
    output logic                             instruction_ready_,
    input  logic [ADDR_WIDTH-1:0]            data_address,
    input  logic                             data_address_strobe_,
    input  logic                             data_read_write,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] data_byte_enable,
    input  logic [DATA_WIDTH-1:0]            data_write_data,
    output logic [DATA_WIDTH-1:0]            data_read_data,
    output logic                             data_ready_,
    output logic                             clear_busy,
    output logic                             collision
);
    localparam int NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam spm_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ?
        YUTORINA_SPM_STATE_CLEAR : YUTORINA_SPM_STATE_RUN;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    spm_state_t            state, state_nx;
    logic [ADDR_WIDTH-1:0] clear_ptr, clear_ptr_nx;
    logic run, a_req, b_req, a_rd, a_wr, b_rd, b_wr, same_addr, both_wr;
    logic a_seen, b_seen;
    logic [NUM_LANES-1:0]  a_be_arb, ram_a_be;
    logic [ADDR_WIDTH-1:0] ram_a_addr;
    logic [DATA_WIDTH-1:0] ram_a_wdata, a_q, b_q, a_out, b_out;

    assign run       = (state == YUTORINA_SPM_STATE_RUN);
    assign clear_busy = !run;
    assign a_req     = run && (instruction_address_strobe_ == ENABLE_);
    assign b_req     = run && (data_address_strobe_ == ENABLE_);
    assign a_rd      = a_req && (instruction_read_write == READ);
    assign a_wr      = a_req && (instruction_read_write == WRITE);
    assign b_rd      = b_req && (data_read_write == READ);
    assign b_wr      = b_req && (data_read_write == WRITE);
    assign same_addr = (instruction_address == data_address);
    assign both_wr   = a_wr && b_wr && same_addr;

    // Port B owns every lane it enables on a same-word write/write.
    assign a_be_arb = instruction_byte_enable &
                      ~(both_wr ? data_byte_enable : '0);

    // Port A is borrowed by the zero-fill sequence while clearing.
    assign ram_a_be    = run ? a_be_arb : '1;
    assign ram_a_addr  = run ? instruction_address : clear_ptr;
    assign ram_a_wdata = run ? instruction_write_data : '0;

    always_comb begin
        state_nx     = state;
        clear_ptr_nx = clear_ptr;
        unique case (state)
            YUTORINA_SPM_STATE_CLEAR: begin
                clear_ptr_nx = clear_ptr + 1'b1;
                if (clear_ptr == '1) state_nx = YUTORINA_SPM_STATE_RUN;
            end
            YUTORINA_SPM_STATE_RUN: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state             <= RESET_STATE;
            clear_ptr         <= '0;
            instruction_ready_ <= DISABLE_;
            data_ready_       <= DISABLE_;
            collision         <= 1'b0;
            a_seen            <= 1'b0;
            b_seen            <= 1'b0;
        end else begin
            state             <= state_nx;
            clear_ptr         <= clear_ptr_nx;
            instruction_ready_ <= !a_req;
            data_ready_       <= !b_req;
            collision         <= both_wr &&
                                 |(instruction_byte_enable & data_byte_enable);
            a_seen            <= a_seen || a_rd;
            b_seen            <= b_seen || b_rd;
        end
    end

    yutorina_spm_ram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .BYTE_WIDTH(BYTE_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_core (
        .clock  (clock),
        .a_re   (a_rd),
        .a_we   (a_wr || !run),
        .a_be   (ram_a_be),
        .a_addr (ram_a_addr),
        .a_wdata(ram_a_wdata),
        .a_rdata(a_q),
        .b_re   (b_rd),
        .b_we   (b_wr),
        .b_be   (data_byte_enable),
        .b_addr (data_address),
        .b_wdata(data_write_data),
        .b_rdata(b_q)
    );

`ifdef YUTORINA_SPM_BYPASS_EN
    logic [NUM_LANES-1:0]  a_fwd_mask, b_fwd_mask;
    logic [DATA_WIDTH-1:0] a_fwd_data, b_fwd_data;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            a_fwd_mask <= '0;
            b_fwd_mask <= '0;
            a_fwd_data <= '0;
            b_fwd_data <= '0;
        end else begin
            if (a_rd) begin
                a_fwd_mask <= (b_wr && same_addr) ? data_byte_enable : '0;
                a_fwd_data <= data_write_data;
            end
            if (b_rd) begin
                b_fwd_mask <= (a_wr && same_addr) ? instruction_byte_enable : '0;
                b_fwd_data <= instruction_write_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_fwd
        assign a_out[i*BYTE_WIDTH +: BYTE_WIDTH] = a_fwd_mask[i] ?
            a_fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH] : a_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        assign b_out[i*BYTE_WIDTH +: BYTE_WIDTH] = b_fwd_mask[i] ?
            b_fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH] : b_q[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
`else
    assign a_out = a_q;
    assign b_out = b_q;
`endif

    // RAM output has no reset; mask it until the first read after reset.
    assign instruction_read_data = a_seen ? a_out : '0;
    assign data_read_data        = b_seen ? b_out : '0;

endmodule

// File: tb/tb_yutorina_spm_dpx.sv
// Scoreboard bench for yutorina_spm_dpx (ADDR_WIDTH=4, 32-bit words).
module tb_yutorina_spm_dpx;
    import yutorina_spm_dpx_pkg::*;

`ifdef YUTORINA_SPM_BYPASS_EN
    localparam logic [31:0] RAW_EXP = 32'h12345678;
`else
    localparam logic [31:0] RAW_EXP = 32'h00000000;
`endif

    logic        clock = 1'b0;
    logic        reset_;
    logic [3:0]  ia, da;
    logic        ias_, das_, irw, drw;
    logic [3:0]  ibe, dbe;
    logic [31:0] iwd, dwd, ird, drd;
    logic        irdy_, drdy_, clear_busy, collision;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [31:0] last_a, last_b;
    int errors = 0;
    int checks = 0;

    yutorina_spm_dpx #(
        .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1)
    ) dut (
        .clock(clock), .reset_(reset_),
        .instruction_address(ia), .instruction_address_strobe_(ias_),
        .instruction_read_write(irw), .instruction_byte_enable(ibe),
        .instruction_write_data(iwd), .instruction_read_data(ird),
        .instruction_ready_(irdy_),
        .data_address(da), .data_address_strobe_(das_),
        .data_read_write(drw), .data_byte_enable(dbe),
        .data_write_data(dwd), .data_read_data(drd),
        .data_ready_(drdy_),
        .clear_busy(clear_busy), .collision(collision)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (reset_ && irdy_ == ENABLE_) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_ack: got ready_=0 expected 1");
            end else begin
                e = qa.pop_front();
                if (e.rd) begin
                    check("a_read", ird, e.data);
                    last_a = e.data;
                end else check("a_hold_on_write", ird, last_a);
            end
        end
        if (reset_ && drdy_ == ENABLE_) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_ack: got ready_=0 expected 1");
            end else begin
                e = qb.pop_front();
                if (e.rd) begin
                    check("b_read", drd, e.data);
                    last_b = e.data;
                end else check("b_hold_on_write", drd, last_b);
            end
        end
    end

    // One request cycle; entered and left at posedge+1.
    task automatic cyc(
        input logic av, input logic arw, input logic [3:0] abe,
        input logic [3:0] aad, input logic [31:0] awd, input logic [31:0] aexp,
        input logic bv, input logic brw, input logic [3:0] bbe,
        input logic [3:0] bad, input logic [31:0] bwd, input logic [31:0] bexp);
        ias_ = !av; irw = arw; ibe = abe; ia = aad; iwd = awd;
        das_ = !bv; drw = brw; dbe = bbe; da = bad; dwd = bwd;
        if (av) qa.push_back('{rd: (arw == READ), data: aexp});
        if (bv) qb.push_back('{rd: (brw == READ), data: bexp});
        @(posedge clock); #1;
        ias_ = DISABLE_; das_ = DISABLE_;
    endtask

    task automatic rd_a(input logic [3:0] ad, input logic [31:0] exp);
        cyc(1, READ, 4'h0, ad, 32'h0, exp, 0, READ, 4'h0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr_b(input logic [3:0] ad, input logic [3:0] be,
                        input logic [31:0] wd);
        cyc(0, READ, 4'h0, 4'h0, 32'h0, 32'h0, 1, WRITE, be, ad, wd, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic count_clear(input string name);
        int cnt, bad;
        cnt = 0; bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!clear_busy) break;
            cnt++;
            if (irdy_ !== DISABLE_ || drdy_ !== DISABLE_) bad++;
        end
        check({name, "_cycles"}, cnt, 16);
        check({name, "_ready_held"}, bad, 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_a_rdy"}, irdy_, DISABLE_);
        check({name, "_b_rdy"}, drdy_, DISABLE_);
        check({name, "_a_data"}, ird, 32'h0);
        check({name, "_b_data"}, drd, 32'h0);
        check({name, "_busy"}, clear_busy, 1'b1);
        check({name, "_coll"}, collision, 1'b0);
    endtask

    initial begin
        last_a = '0; last_b = '0;
        reset_ = 1'b0;
        ias_ = ENABLE_; irw = READ; ibe = 4'h0; ia = 4'h0; iwd = '0;
        das_ = ENABLE_; drw = READ; dbe = 4'h0; da = 4'h0; dwd = '0;
        #12;
        check_reset_vals("reset");
        @(posedge clock); #1;
        reset_ = 1'b1;

        // Held strobes must wait out the fill, then be accepted once.
        count_clear("clear1");
        qa.push_back('{rd: 1'b1, data: 32'h0});
        qb.push_back('{rd: 1'b1, data: 32'h0});
        @(posedge clock); #1;
        ias_ = DISABLE_; das_ = DISABLE_;

        for (int i = 1; i < 16; i++) rd_a(4'(i), 32'h0);

        wr_b(4'd5, 4'b1111, 32'hDEADBEEF);
        rd_a(4'd5, 32'hDEADBEEF);

        wr_b(4'd7, 4'b1111, 32'h11223344);
        wr_b(4'd7, 4'b0101, 32'hAABBCCDD);
        rd_a(4'd7, 32'h11BB33DD);

        cyc(1, WRITE, 4'b1111, 4'd9, 32'h01010101, 32'h0,
            1, WRITE, 4'b0011, 4'd9, 32'h02020202, 32'h0);
        @(negedge clock);
        check("collision_pulse", collision, 1'b1);
        @(posedge clock); #1;
        @(negedge clock);
        check("collision_one_cycle", collision, 1'b0);
        @(posedge clock); #1;
        rd_a(4'd9, 32'h01010202);

        cyc(1, WRITE, 4'b1100, 4'd10, 32'hA0A0A0A0, 32'h0,
            1, WRITE, 4'b0000, 4'd10, 32'hFFFFFFFF, 32'h0);
        @(negedge clock);
        check("no_collision_be0", collision, 1'b0);
        @(posedge clock); #1;
        cyc(1, WRITE, 4'b1100, 4'd11, 32'hA1A2A3A4, 32'h0,
            1, WRITE, 4'b0011, 4'd11, 32'hB1B2B3B4, 32'h0);
        @(negedge clock);
        check("no_collision_disjoint", collision, 1'b0);
        @(posedge clock); #1;
        rd_a(4'd10, 32'hA0A00000);
        rd_a(4'd11, 32'hA1A2B3B4);

        cyc(1, READ, 4'h0, 4'd3, 32'h0, RAW_EXP,
            1, WRITE, 4'b1111, 4'd3, 32'h12345678, 32'h0);
        rd_a(4'd3, 32'h12345678);
        idle(3);
        check("queues_drained", 32'(qa.size() + qb.size()), 32'd0);

        // Async reset from RUN: outputs drop without a clock edge.
        @(negedge clock); #2;
        reset_ = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(posedge clock); #1;
        reset_ = 1'b1;
        idle(5);
        @(negedge clock); #2;
        reset_ = 1'b0;
        #1;
        check("mid_clear_busy", clear_busy, 1'b1);
        @(posedge clock); #1;
        reset_ = 1'b1;
        count_clear("clear2");
        @(posedge clock); #1;
        rd_a(4'd5, 32'h0);
        rd_a(4'd9, 32'h0);
        idle(3);
        check("queues_drained_end", 32'(qa.size() + qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
